// File: rtl/freq_meter_gen_if.sv
// Bundles the frequency meter's control inputs and published result.
// Latency: none, wires only.
// Backpressure: none; valid is a strobe that the consumer must capture.
interface freq_meter_gen_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 32
);
   logic [DATA_W-1:0] wave_in;
   logic              start;
   logic              stop;
   logic              cont;
   logic [1:0]        gate_sel;
   logic [CNT_W-1:0]  freq_data;
   logic [1:0]        freq_sel;
   logic              valid;
   logic              overflow;
   logic              busy;

   // Stimulus and readout side.
   modport master (
      output wave_in, start, stop, cont, gate_sel,
      input  freq_data, freq_sel, valid, overflow, busy
   );

   // Meter side.
   modport slave (
      input  wave_in, start, stop, cont, gate_sel,
      output freq_data, freq_sel, valid, overflow, busy
   );
endinterface

// File: rtl/freq_meter_gen.sv
// Gated frequency meter: squares wave_in with a hysteresis comparator and counts rising crossings per gate window.
// Latency: a wave_in crossing is counted 2 clk later; the result is published on the edge that ends the window.
// Backpressure: none; valid is a one-cycle strobe, and freq_data holds until the next publish.
module freq_meter_gen #(
   parameter int DATA_W      = 8,
   parameter int CNT_W       = 32,
   parameter int GATE_CYCLES = 10000,
   parameter int MID         = 128,
   parameter int HYST        = 16
) (
   input logic             clk,
   input logic             rst,
   freq_meter_gen_if.slave bus
);
   localparam int GW = $clog2(GATE_CYCLES + 1);
   localparam logic [DATA_W-1:0] TH_HI   = DATA_W'(MID + HYST);
   localparam logic [DATA_W-1:0] TH_LO   = DATA_W'(MID - HYST);
   localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_GATE = 1'b1;

   // The terminal value of gate_cnt (G-1) is stored so that the end-of-window test is a plain compare.
   function automatic logic [GW-1:0] gate_last(input logic [1:0] sel);
      int g;
      case (sel)
         2'd0:    g = GATE_CYCLES;
         2'd1:    g = GATE_CYCLES / 10;
         2'd2:    g = GATE_CYCLES / 100;
         default: g = GATE_CYCLES / 1000;
      endcase
      return GW'(g - 1);
   endfunction

   logic [DATA_W-1:0] s_q;
   logic              h_q, h_d;
   logic              rise;
   logic [0:0]        state_q, state_d;
   logic [GW-1:0]     gate_cnt_q, gate_cnt_d;
   logic [GW-1:0]     glast_q, glast_d;
   logic [1:0]        sel_q, sel_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              sat_q, sat_d;
   logic [CNT_W-1:0]  freq_data_q, freq_data_d;
   logic [1:0]        freq_sel_q, freq_sel_d;
   logic              valid_q, valid_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  cnt_next;
   logic              sat_next;

   // Schmitt decision on the registered sample. Inside the band the previous decision is held.
   always_comb begin
      h_d = h_q;
      if (s_q >= TH_HI) begin
         h_d = 1'b1;
      end else if (s_q <= TH_LO) begin
         h_d = 1'b0;
      end
      rise     = h_d & ~h_q;
      cnt_next = (rise && edge_cnt_q != CNT_MAX) ? edge_cnt_q + 1'b1 : edge_cnt_q;
      sat_next = sat_q | (rise && edge_cnt_q == CNT_MAX);
   end

   // Input stage. It runs in every state, so h is never stale when a window opens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q <= '0;
         h_q <= 1'b0;
      end else begin
         s_q <= bus.wave_in;
         h_q <= h_d;
      end
   end

   // Window control. stop wins over everything; the last gate cycle publishes and either restarts or idles.
   always_comb begin
      state_d     = state_q;
      gate_cnt_d  = gate_cnt_q;
      glast_d     = glast_q;
      sel_d       = sel_q;
      edge_cnt_d  = edge_cnt_q;
      sat_d       = sat_q;
      freq_data_d = freq_data_q;
      freq_sel_d  = freq_sel_q;
      overflow_d  = overflow_q;
      valid_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d    = S_GATE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
               glast_d    = gate_last(bus.gate_sel);
               sel_d      = bus.gate_sel;
            end
         end
         default: begin
            if (bus.stop) begin
               state_d    = S_IDLE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
            end else if (gate_cnt_q == glast_q) begin
               freq_data_d = cnt_next;
               overflow_d  = sat_next;
               freq_sel_d  = sel_q;
               valid_d     = 1'b1;
               gate_cnt_d  = '0;
               edge_cnt_d  = '0;
               sat_d       = 1'b0;
               if (bus.cont) begin
                  glast_d = gate_last(bus.gate_sel);
                  sel_d   = bus.gate_sel;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gate_cnt_d = gate_cnt_q + 1'b1;
               edge_cnt_d = cnt_next;
               sat_d      = sat_next;
            end
         end
      endcase
   end

   // State and result registers. An asynchronous reset drops any partial window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         gate_cnt_q  <= '0;
         glast_q     <= '0;
         sel_q       <= '0;
         edge_cnt_q  <= '0;
         sat_q       <= 1'b0;
         freq_data_q <= '0;
         freq_sel_q  <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         gate_cnt_q  <= gate_cnt_d;
         glast_q     <= glast_d;
         sel_q       <= sel_d;
         edge_cnt_q  <= edge_cnt_d;
         sat_q       <= sat_d;
         freq_data_q <= freq_data_d;
         freq_sel_q  <= freq_sel_d;
         valid_q     <= valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.freq_data = freq_data_q;
   assign bus.freq_sel  = freq_sel_q;
   assign bus.valid     = valid_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = (state_q == S_GATE);
endmodule

// File: tb/tb_freq_meter_gen.sv
// Bench for freq_meter_gen: one 32-bit and one 4-bit counter instance share the same stimulus.
// Latency: outputs are checked #1 after each rising edge against an edge-timestamp reference model.
// Backpressure: none; every valid strobe is checked on the cycle it appears.
module tb_freq_meter_gen;
   localparam int RC_N = 40000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   freq_meter_gen_if #(.DATA_W(8), .CNT_W(32)) bus ();
   freq_meter_gen_if #(.DATA_W(8), .CNT_W(4))  bus4 ();

   assign bus4.wave_in  = bus.wave_in;
   assign bus4.start    = bus.start;
   assign bus4.stop     = bus.stop;
   assign bus4.cont     = bus.cont;
   assign bus4.gate_sel = bus.gate_sel;

   freq_meter_gen #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   freq_meter_gen #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   int n_cmp = 0;
   int n_bad = 0;

   // The reference model keeps a running total of rises, indexed by edge number, plus window timestamps.
   int          n = 0;
   int          rc [0:RC_N-1];
   bit          hq = 1'b0;
   int          wprev = 0;
   bit          m_busy = 1'b0;
   bit          m_valid = 1'b0;
   int          m_e = 0;
   int          m_g = 0;
   logic [1:0]  m_lsel = 2'd0;
   logic [1:0]  m_sel = 2'd0;
   longint      m_cnt = 0;
   int          valid_seen = 0;

   typedef struct {
      logic [1:0] sel;
      int         kind;
      int         half;
      longint     exp_fd;
      longint     exp_fd4;
      logic       exp_ov4;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d, wanted %0d", name, n, act, exp);
      end
   endtask

   function automatic int glen(input logic [1:0] sel);
      return 10000 / (10 ** int'(sel));
   endfunction

   function automatic logic [63:0] clampw(input longint c, input int w);
      longint mx;
      mx = (64'sd1 <<< w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   // kind 0: clean 0/255 square; kind 1: same, with 5 cycles of 120/136 chatter at the start of each half.
   function automatic logic [7:0] gen(input int kind, input int half, input int t);
      if (kind == 1 && (t % half) < 5) return (t % 2 == 1) ? 8'd136 : 8'd120;
      return (((t / half) % 2) == 1) ? 8'd255 : 8'd0;
   endfunction

   task automatic model_edge(input logic st, input logic sp, input logic ct,
                             input logic [1:0] sl, input logic [7:0] wv);
      bit hn;
      n = n + 1;
      if (n >= RC_N) begin
         $display("FAIL edge_budget: got %0d edges, limit %0d", n, RC_N);
         $fatal(1, "edge budget exhausted");
      end
      if (rst) begin
         rc[n] = rc[n-1];
         hq = 1'b0; wprev = 0;
         m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_sel = 2'd0;
      end else begin
         hn = (wprev >= 144) ? 1'b1 : (wprev <= 112) ? 1'b0 : hq;
         rc[n] = rc[n-1] + ((hn && !hq) ? 1 : 0);
         hq = hn;
         wprev = int'(wv);
         m_valid = 1'b0;
         if (sp) begin
            m_busy = 1'b0;
         end else if (!m_busy) begin
            if (st) begin
               m_busy = 1'b1; m_e = n; m_g = glen(sl); m_lsel = sl;
            end
         end else if (n == m_e + m_g) begin
            m_cnt = longint'(rc[n] - rc[m_e]);
            m_sel = m_lsel;
            m_valid = 1'b1;
            if (ct) begin
               m_e = n; m_g = glen(sl); m_lsel = sl;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
   endtask

   task automatic step(input logic st, input logic sp, input logic ct,
                       input logic [1:0] sl, input logic [7:0] wv);
      bus.start = st; bus.stop = sp; bus.cont = ct; bus.gate_sel = sl; bus.wave_in = wv;
      @(posedge clk);
      model_edge(st, sp, ct, sl, wv);
      #1;
      if (bus.valid === 1'b1) valid_seen++;
      chk("valid",      bus.valid,      m_valid);
      chk("busy",       bus.busy,       m_busy);
      chk("freq_data",  bus.freq_data,  clampw(m_cnt, 32));
      chk("overflow",   bus.overflow,   m_cnt > 64'sh0FFFFFFFF);
      chk("freq_sel",   bus.freq_sel,   m_sel);
      chk("valid4",     bus4.valid,     m_valid);
      chk("freq_data4", bus4.freq_data, clampw(m_cnt, 4));
      chk("overflow4",  bus4.overflow,  m_cnt > 15);
   endtask

   task automatic run(input int cyc, input logic st, input logic sp, input logic ct,
                      input logic [1:0] sl, input int kind, input int half);
      for (int k = 0; k < cyc; k++) step(st, sp, ct, sl, gen(kind, half, n));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int vs;
      int rhalf;
      logic rct;
      logic [1:0] rsel;
      logic [7:0] w;

      tbl[0] = '{sel: 2'd0, kind: 0, half: 50,  exp_fd: 100, exp_fd4: 15, exp_ov4: 1'b1};
      tbl[1] = '{sel: 2'd2, kind: 0, half: 50,  exp_fd: 1,   exp_fd4: 1,  exp_ov4: 1'b0};
      tbl[2] = '{sel: 2'd1, kind: 1, half: 25,  exp_fd: 20,  exp_fd4: 15, exp_ov4: 1'b1};
      tbl[3] = '{sel: 2'd1, kind: 0, half: 5,   exp_fd: 100, exp_fd4: 15, exp_ov4: 1'b1};
      tbl[4] = '{sel: 2'd1, kind: 0, half: 100, exp_fd: 5,   exp_fd4: 5,  exp_ov4: 1'b0};
      tbl[5] = '{sel: 2'd3, kind: 0, half: 1,   exp_fd: 5,   exp_fd4: 5,  exp_ov4: 1'b0};
      rc[0] = 0;

      bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0; bus.gate_sel = 2'd0; bus.wave_in = 8'd0;
      #2;
      chk("rst_freq_data", bus.freq_data, 0);
      chk("rst_valid",     bus.valid,     0);
      chk("rst_busy",      bus.busy,      0);
      chk("rst_overflow",  bus.overflow,  0);
      chk("rst_freq_sel",  bus.freq_sel,  0);
      run(3, 1'b1, 1'b0, 1'b0, 2'd0, 0, 50);
      rst = 1'b0;

      // Single-shot windows from the vector table.
      for (int i = 0; i < 6; i++) begin
         run(300, 1'b0, 1'b0, 1'b0, tbl[i].sel, tbl[i].kind, tbl[i].half);
         step(1'b1, 1'b0, 1'b0, tbl[i].sel, gen(tbl[i].kind, tbl[i].half, n));
         run(glen(tbl[i].sel), 1'b0, 1'b0, 1'b0, tbl[i].sel, tbl[i].kind, tbl[i].half);
         chk("tbl_valid", bus.valid,      1);
         chk("tbl_fd",    bus.freq_data,  tbl[i].exp_fd);
         chk("tbl_ov",    bus.overflow,   0);
         chk("tbl_sel",   bus.freq_sel,   tbl[i].sel);
         chk("tbl_busy",  bus.busy,       0);
         chk("tbl_fd4",   bus4.freq_data, tbl[i].exp_fd4);
         chk("tbl_ov4",   bus4.overflow,  tbl[i].exp_ov4);
      end

      // Continuous G=100: five back-to-back publishes, busy held.
      run(300, 1'b0, 1'b0, 1'b1, 2'd2, 0, 50);
      step(1'b1, 1'b0, 1'b1, 2'd2, gen(0, 50, n));
      vs = valid_seen;
      run(500, 1'b0, 1'b0, 1'b1, 2'd2, 0, 50);
      chk("cont_valids", valid_seen - vs, 5);
      chk("cont_busy",   bus.busy,        1);
      chk("cont_fd",     bus.freq_data,   1);
      run(50, 1'b0, 1'b0, 1'b1, 2'd2, 0, 50);
      step(1'b0, 1'b1, 1'b1, 2'd2, gen(0, 50, n));
      chk("cont_stop_busy", bus.busy, 0);

      // Abort at cycle 500 of 1000, then a fresh window with start held for a while mid-window.
      run(300, 1'b0, 1'b0, 1'b0, 2'd1, 0, 5);
      step(1'b1, 1'b0, 1'b0, 2'd1, gen(0, 5, n));
      vs = valid_seen;
      run(499, 1'b0, 1'b0, 1'b0, 2'd1, 0, 5);
      step(1'b0, 1'b1, 1'b0, 2'd1, gen(0, 5, n));
      chk("stop_busy",  bus.busy,      0);
      chk("stop_valid", bus.valid,     0);
      chk("stop_fd",    bus.freq_data, 1);
      run(200, 1'b0, 1'b0, 1'b0, 2'd1, 0, 5);
      chk("stop_no_valid", valid_seen - vs, 0);
      step(1'b1, 1'b1, 1'b0, 2'd1, gen(0, 5, n));
      chk("start_stop_idle", bus.busy, 0);
      step(1'b1, 1'b0, 1'b0, 2'd1, gen(0, 5, n));
      run(100, 1'b0, 1'b0, 1'b0, 2'd1, 0, 5);
      run(10, 1'b1, 1'b0, 1'b0, 2'd1, 0, 5);
      run(890, 1'b0, 1'b0, 1'b0, 2'd1, 0, 5);
      chk("restart_valid", bus.valid,      1);
      chk("restart_fd",    bus.freq_data,  100);
      chk("restart_fd4",   bus4.freq_data, 15);
      chk("restart_ov4",   bus4.overflow,  1);

      // Rise landing on the last gate cycle is counted; one edge later it is not.
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 2'd3, 8'd0);
      step(1'b1, 1'b0, 1'b0, 2'd3, 8'd0);
      for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 1'b0, 2'd3, (k >= 9) ? 8'd255 : 8'd0);
      chk("last_rise_valid", bus.valid,     1);
      chk("last_rise_fd",    bus.freq_data, 1);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 2'd3, 8'd0);
      step(1'b1, 1'b0, 1'b0, 2'd3, 8'd0);
      for (int k = 1; k <= 10; k++) step(1'b0, 1'b0, 1'b0, 2'd3, (k == 10) ? 8'd255 : 8'd0);
      chk("late_rise_fd", bus.freq_data, 0);

      // Asynchronous reset mid-window in continuous mode, then a clean measurement.
      run(300, 1'b0, 1'b0, 1'b1, 2'd2, 0, 50);
      step(1'b1, 1'b0, 1'b1, 2'd2, gen(0, 50, n));
      run(150, 1'b0, 1'b0, 1'b1, 2'd2, 0, 50);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_fd",    bus.freq_data, 0);
      chk("arst_valid", bus.valid,     0);
      chk("arst_busy",  bus.busy,      0);
      run(2, 1'b0, 1'b0, 1'b1, 2'd2, 0, 50);
      rst = 1'b0;
      run(150, 1'b0, 1'b0, 1'b0, 2'd2, 0, 50);
      step(1'b1, 1'b0, 1'b0, 2'd2, gen(0, 50, n));
      run(100, 1'b0, 1'b0, 1'b0, 2'd2, 0, 50);
      chk("post_rst_fd", bus.freq_data, 1);

      // Random traffic against the reference model.
      rhalf = 7; rct = 1'b0; rsel = 2'd3;
      for (int k = 0; k < 6000; k++) begin
         if ($urandom_range(0, 99) == 0) rhalf = int'($urandom_range(1, 30));
         if ($urandom_range(0, 199) == 0) rct = ($urandom_range(0, 1) == 1);
         rsel = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd3;
         w = gen(0, rhalf, n);
         if ($urandom_range(0, 3) == 0) w = 8'($urandom_range(0, 255));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0, rct, rsel, w);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/freq_meter_gen.md
Name: freq_meter_gen

Overview:
- Parametrised gated frequency meter for the 8-bit DDS output path.
- Squares the sampled waveform with a hysteresis comparator, counts rising crossings over a selectable gate window, and publishes the count with a valid strobe.
- Supports single-shot and continuous modes, saturation/overflow flagging, and abort.
- Sits after the waveform generator in the 10 kHz sampling domain and feeds the display/readout logic.

Parameters:
- DATA_W, 8, width of the sampled waveform (unsigned).
- CNT_W, 32, width of the edge counter and freq_data.
- GATE_CYCLES, 10000, base gate length in clk cycles (1 s at 10 kHz, so the count equals Hz).
- MID, 128, comparator midpoint.
- HYST, 16, hysteresis half-width. Requires MID-HYST >= 0 and MID+HYST <= 2^DATA_W-1.

Ports:
- clk  in  1  sampling clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wave_in  in  DATA_W  sampled waveform, unsigned.
- start  in  1  level/pulse; begins a measurement from IDLE.
- stop  in  1  abort; returns to IDLE with no publish.
- cont  in  1  1 = continuous back-to-back windows, 0 = single-shot.
- gate_sel  in  2  window length: 0 = GATE_CYCLES, 1 = /10, 2 = /100, 3 = /1000 (integer division).
- freq_data  out  CNT_W  last published edge count.
- freq_sel  out  2  gate_sel value that produced freq_data.
- valid  out  1  one-cycle strobe when freq_data updates.
- overflow  out  1  published window saturated.
- busy  out  1  high while in GATE.

Behaviour:
- Reset values (asynchronous): freq_data=0, freq_sel=0, valid=0, overflow=0, busy=0, state=IDLE, sample register=0, schmitt state h=0, counters=0.
- Input stage: wave_in is registered into s every cycle.
  - h sets when s >= MID+HYST and clears when s <= MID-HYST; otherwise h holds.
  - rise = h goes 0->1, seen in the cycle h updates.
  - Latency from wave_in crossing to rise is 2 clk.
- Gate length: G is computed from gate_sel and latched at window start. Changes to gate_sel mid-window are ignored. G >= 1 is guaranteed by parameter choice.
- State IDLE:
  - busy=0.
  - start=1 and stop=0 -> GATE; gate_cnt=0, edge_cnt=0, latch G.
- State GATE:
  - busy=1.
  - Each cycle: gate_cnt++. If rise, edge_cnt++, saturating at 2^CNT_W-1 with a sticky sat flag set.
  - At the cycle where gate_cnt==G-1, the published count includes any rise in that same cycle. On the next edge: freq_data <= final count, freq_sel <= latched sel, overflow <= sat, valid=1 for one cycle.
  - cont=1 at the last cycle: restart immediately with no dead cycle. gate_cnt=0, edge_cnt=0, sat=0, relatch G; busy stays 1.
  - cont=0 at the last cycle: go to IDLE.
- start while busy is ignored.
- stop has priority over everything, including a window's last cycle. It goes to IDLE, suppresses valid, keeps freq_data unchanged, and clears edge_cnt/sat.
- start and stop together in IDLE: stay in IDLE.
- rst mid-window: all outputs return to reset values immediately; no partial publish.
- The schmitt state h runs continuously, including in IDLE, so the first window does not count a spurious edge from stale h.
- valid is never high for two consecutive cycles unless G==1 in continuous mode, where it pulses every cycle.
- Window boundaries are the only meaning of the count. Frequency = freq_data * (clk rate / G); conversion is left to the consumer.

Test Plan:
- GATE_CYCLES=10000, gate_sel=0, cont=0, full-scale square wave (0/255) with period 100 clk, start pulse -> exactly one valid 10000 cycles after the GATE entry edge (±1 for the registered strobe); freq_data=100, overflow=0, busy falls with valid.
- Same stimulus with gate_sel=2 (G=100), cont=1 -> valid every 100 cycles back-to-back; each freq_data=1 once phase settles; busy held high.
- Noisy wave toggling 120<->136 (inside the 112..144 band) plus a clean 0/255 square of period 50, G=1000 -> freq_data=20; in-band chatter adds no edges.
- CNT_W=4, G=1000, square wave of period 10 (100 edges) -> freq_data=15, overflow=1. Next window with period 200 (5 edges) -> freq_data=5, overflow=0.
- stop asserted mid-window (cycle 500 of 1000) -> no valid, freq_data unchanged, busy=0 next cycle. Then start -> fresh full window.
- rst pulse mid-window in continuous mode -> freq_data=0, valid=0, busy=0 asynchronously; start after release gives a correct count. A rise on the last gate cycle is included in that window's count.
